conv3x3_engine: RTL and testbench

- Downstream consumer of the 3x3 window buffer in the convolution path.
- Samples the nine window taps every cycle and tracks pixel row/column to flag which windows lie fully inside the image.
- Computes a signed 3x3 multiply-accumulate plus bias through a 4-stage pipeline, then applies shift, ReLU and unsigned saturation.
- Emits one output pixel per valid window with a valid strobe; weights are loaded through a register-write port while idle.

---
 rtl/conv3x3_engine_pkg.sv | 27 ++
 rtl/conv3x3_engine_if.sv | 32 +++
 rtl/conv3x3_engine_mac.sv | 78 +++++++
 rtl/conv3x3_engine.sv | 177 +++++++++++++++++
 tb/tb_conv3x3_engine.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv3x3_engine_pkg.sv
// conv3x3_engine_pkg
// Shared definitions for the 3x3 convolution path: FSM states, kernel
// addressing constants, accumulator width helper and a ReLU/saturation
// helper that later layers can reuse.
package conv3x3_engine_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int         KTAPS       = 9;
  localparam logic [3:0] K_ADDR_BIAS = 4'd9;

  // Nine (2*dw+1)-bit products plus a bias need 2*dw+5 bits to never overflow
  function automatic int acc_width(input int dw);
    return 2 * dw + 5;
  endfunction

  // ReLU followed by an unsigned clamp to [0, 2^dw-1]. Takes a wide signed
  // value so any accumulator width up to 64 bits can use it.
  function automatic logic [31:0] sat_relu(input logic signed [63:0] v, input int dw);
    logic signed [63:0] max_val;
    max_val = (64'sd1 <<< dw) - 64'sd1;
    if (v < 64'sd0) return 32'd0;
    if (v > max_val) return max_val[31:0];
    return v[31:0];
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// conv3x3_engine_if
// Bundles the window-tap stream, the kernel register-write port and the
// result/status outputs of the convolution engine.
//   master : drives pix_valid, sof, w11..w33, k_we, k_addr, k_data
//   slave  : drives conv_out, conv_valid, frame_done, frame_err, k_err
interface conv3x3_engine_if #(parameter int DATA_WIDTH = 8);

  logic                  pix_valid;
  logic                  sof;
  logic [DATA_WIDTH-1:0] w11, w12, w13, w21, w22, w23, w31, w32, w33;
  logic                  k_we;
  logic [3:0]            k_addr;
  logic [DATA_WIDTH-1:0] k_data;
  logic [DATA_WIDTH-1:0] conv_out;
  logic                  conv_valid;
  logic                  frame_done;
  logic                  frame_err;
  logic                  k_err;

  modport master (
    output pix_valid, sof, w11, w12, w13, w21, w22, w23, w31, w32, w33,
    output k_we, k_addr, k_data,
    input  conv_out, conv_valid, frame_done, frame_err, k_err
  );

  modport slave (
    input  pix_valid, sof, w11, w12, w13, w21, w22, w23, w31, w32, w33,
    input  k_we, k_addr, k_data,
    output conv_out, conv_valid, frame_done, frame_err, k_err
  );

endinterface

// File: rtl/conv3x3_engine_mac.sv
// conv3x3_mac
// Four-stage signed 3x3 multiply-accumulate datapath with bias, shift,
// ReLU and unsigned saturation. No stall; flush drops everything in flight.
//   clk, rst_n        : clock, async active-low reset
//   flush             : clear all stage valid bits this edge
//   in_valid          : taps hold a valid window this cycle
//   taps[0..8]        : unsigned pixels, row-major (0 = w11)
//   weights[0..8]     : signed weights, row-major
//   bias              : signed bias
//   conv_out          : saturated result, holds when conv_valid is low
//   conv_valid        : conv_out updated this cycle
module conv3x3_mac
  import conv3x3_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 0,
  parameter int ACC_W      = acc_width(DATA_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [KTAPS-1:0][DATA_WIDTH-1:0] taps,
  input  logic [KTAPS-1:0][DATA_WIDTH-1:0] weights,
  input  logic [DATA_WIDTH-1:0]            bias,
  output logic [DATA_WIDTH-1:0]            conv_out,
  output logic                             conv_valid
);

  localparam int PW = 2 * DATA_WIDTH + 1;

  logic signed [PW-1:0]    prod    [KTAPS];
  logic signed [ACC_W-1:0] row_sum [3];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic [2:0]              vld;

  assign shifted = acc >>> SHIFT;

  // Stages 1-3: products (pixel zero-extended so it stays non-negative),
  // per-row partial sums, then the total with the sign-extended bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KTAPS; i++) prod[i] <= '0;
      for (int r = 0; r < 3; r++) row_sum[r] <= '0;
      acc <= '0;
    end else begin
      for (int i = 0; i < KTAPS; i++)
        prod[i] <= PW'($signed({1'b0, taps[i]})) * PW'($signed(weights[i]));
      for (int r = 0; r < 3; r++)
        row_sum[r] <= ACC_W'(prod[3*r]) + ACC_W'(prod[3*r+1]) + ACC_W'(prod[3*r+2]);
      acc <= row_sum[0] + row_sum[1] + row_sum[2] + ACC_W'($signed(bias));
    end
  end

  // Stage valid bits travel alongside the data; flush kills a half-done frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld        <= '0;
      conv_valid <= 1'b0;
    end else if (flush) begin
      vld        <= '0;
      conv_valid <= 1'b0;
    end else begin
      vld        <= {vld[1:0], in_valid};
      conv_valid <= vld[2];
    end
  end

  // Stage 4: only a valid accumulator updates the output, so it holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conv_out <= '0;
    else if (vld[2] && !flush)
      conv_out <= DATA_WIDTH'(sat_relu(64'(shifted), DATA_WIDTH));
  end

endmodule

// File: rtl/conv3x3_engine.sv
// conv3x3_engine
// Frame-level control for the 3x3 convolution: tags incoming pixels with
// row/column, aligns the tags with the window taps, decides which windows
// are fully inside the image, owns the kernel registers and feeds the MAC.
//   clk, rst_n : clock, async active-low reset
//   bus        : conv3x3_engine_if slave (taps, kernel port, results)
module conv3x3_engine
  import conv3x3_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int WIN_LAT    = 1,
  parameter int SHIFT      = 0,
  parameter int ACC_W      = acc_width(DATA_WIDTH)
) (
  input logic              clk,
  input logic              rst_n,
  conv3x3_engine_if.slave  bus
);

  localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam int DCW    = $clog2(WIN_LAT + 5);
  localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(WIN_LAT + 3);

  state_t                           state;
  logic [RW-1:0]                    row_cnt, cur_row;
  logic [CW-1:0]                    col_cnt, cur_col;
  logic [DCW-1:0]                   drain_cnt;
  logic                             tag_vld [WIN_LAT];
  logic [RW-1:0]                    tag_row [WIN_LAT];
  logic [CW-1:0]                    tag_col [WIN_LAT];
  logic [KTAPS-1:0][DATA_WIDTH-1:0] kern;
  logic [DATA_WIDTH-1:0]            bias;
  logic [KTAPS-1:0][DATA_WIDTH-1:0] taps;
  logic                             accept, abort, win_valid;
  logic                             done_pulse, err_pulse, kerr_pulse;

  assign taps = {bus.w33, bus.w32, bus.w31, bus.w23, bus.w22, bus.w21,
                 bus.w13, bus.w12, bus.w11};

  // Decide whether this cycle's pixel belongs to a frame and what tag it
  // gets; in RUN anything but a plain pixel (gap or stray sof) aborts.
  always_comb begin
    accept  = 1'b0;
    abort   = 1'b0;
    cur_row = row_cnt;
    cur_col = col_cnt;
    case (state)
      IDLE: begin
        accept  = bus.pix_valid && bus.sof;
        cur_row = '0;
        cur_col = '0;
      end
      RUN: begin
        accept = bus.pix_valid && !bus.sof;
        abort  = !accept;
      end
      default: ;
    endcase
  end

  // Tag delay line matches the window buffer latency so the tag lines up
  // with the pixel currently at w33.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_row[i] <= '0;
        tag_col[i] <= '0;
      end
    end else begin
      tag_vld[0] <= accept;
      tag_row[0] <= cur_row;
      tag_col[0] <= cur_col;
      for (int i = 1; i < WIN_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_row[i] <= tag_row[i-1];
        tag_col[i] <= tag_col[i-1];
      end
      if (abort)
        for (int i = 0; i < WIN_LAT; i++) tag_vld[i] <= 1'b0;
    end
  end

  assign win_valid = tag_vld[WIN_LAT-1] && (tag_row[WIN_LAT-1] >= RW'(2)) &&
                     (tag_col[WIN_LAT-1] >= CW'(2));

  // Frame FSM, raster counters, kernel registers and status pulses.
  // Counters hold the position of the next expected pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_cnt    <= '0;
      col_cnt    <= '0;
      drain_cnt  <= '0;
      kern       <= '0;
      bias       <= '0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      kerr_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      kerr_pulse <= 1'b0;
      if (bus.k_we) begin
        if (state == IDLE && bus.k_addr <= K_ADDR_BIAS) begin
          if (bus.k_addr == K_ADDR_BIAS) bias <= bus.k_data;
          else                           kern[bus.k_addr] <= bus.k_data;
        end else begin
          kerr_pulse <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= RUN;
            row_cnt <= '0;
            col_cnt <= CW'(1);
          end
        end
        RUN: begin
          if (abort) begin
            err_pulse <= 1'b1;
            row_cnt   <= '0;
            col_cnt   <= '0;
            state     <= IDLE;
          end else if (cur_row == ROW_LAST && cur_col == COL_LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
          end else if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + RW'(1);
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        DRAIN: begin
          // Last drain cycle is the one carrying the final conv_valid
          if (drain_cnt == DRAIN_LAST) begin
            done_pulse <= 1'b1;
            state      <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.frame_done = done_pulse;
  assign bus.frame_err  = err_pulse;
  assign bus.k_err      = kerr_pulse;

  conv3x3_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT      (SHIFT),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (abort),
    .in_valid   (win_valid),
    .taps       (taps),
    .weights    (kern),
    .bias       (bias),
    .conv_out   (bus.conv_out),
    .conv_valid (bus.conv_valid)
  );

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine
// Directed bench for conv3x3_engine on an 8x8 image. The stimulus process
// plays the role of the window buffer (taps appear one cycle after the
// pixel) and pushes the hand-derived result of every in-image window into
// a queue; a monitor pops and compares on each conv_valid.
module tb_conv3x3_engine;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  conv3x3_engine_if #(.DATA_WIDTH(DW)) bus ();

  conv3x3_engine #(
    .DATA_WIDTH (DW),
    .IMG_W      (8),
    .IMG_H      (8),
    .WIN_LAT    (1),
    .SHIFT      (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int img [8][8];
  int valid_cnt = 0, done_cnt = 0, err_cnt = 0, kerr_cnt = 0;
  int base_valid, base_done;
  int cyc = 0;
  int first_cyc = -1;
  int tap22_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on every conv_valid, plus pulse counting
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.conv_valid === 1'b1) begin
        valid_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        if (exp_q.size() == 0) checkOutput("unexpected_valid", int'(bus.conv_valid), 0);
        else                   checkOutput("conv_out", int'(bus.conv_out), exp_q.pop_front());
      end
      if (bus.frame_done === 1'b1) begin
        done_cnt++;
        checkOutput("done_after_last_valid", int'(prev_valid), 1);
      end
      if (bus.frame_err === 1'b1) err_cnt++;
      if (bus.k_err === 1'b1) kerr_cnt++;
      prev_valid = bus.conv_valid;
    end
  end

  function automatic logic [DW-1:0] px(input int r, input int c);
    if (r < 0 || c < 0) return '0;
    return DW'(img[r][c]);
  endfunction

  task automatic set_taps(input int p);
    int r, c;
    r = p / 8;
    c = p % 8;
    bus.w11 = px(r-2, c-2); bus.w12 = px(r-2, c-1); bus.w13 = px(r-2, c);
    bus.w21 = px(r-1, c-2); bus.w22 = px(r-1, c-1); bus.w23 = px(r-1, c);
    bus.w31 = px(r,   c-2); bus.w32 = px(r,   c-1); bus.w33 = px(r,   c);
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = 8 * r + c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.sof       = 1'b0;
      bus.k_we      = 1'b0;
    end
  endtask

  task automatic load_weight(input int addr, input int data);
    @(negedge clk);
    bus.k_we   = 1'b1;
    bus.k_addr = 4'(addr);
    bus.k_data = DW'(data);
    @(negedge clk);
    bus.k_we   = 1'b0;
  endtask

  task automatic load_kernel(input int others, input int centre, input int b);
    for (int i = 0; i < 9; i++) load_weight(i, (i == 4) ? centre : others);
    load_weight(9, b);
  endtask

  // Drives one frame. exp_const < 0 means the centre-tap ramp result
  // 8*(r-1)+(c-1) for the window whose newest pixel is (r,c).
  task automatic applyStimulus(input int exp_const, input int abort_idx,
                               input int kwe_idx, input int rst_idx);
    int r, c;
    base_valid = valid_cnt;
    base_done  = done_cnt;
    first_cyc  = -1;
    for (int p = 0; p <= 64; p++) begin
      @(negedge clk);
      bus.k_we = 1'b0;
      if (p > 0) begin
        set_taps(p - 1);
        if (p - 1 == 18) tap22_cyc = cyc;
      end
      if (p == rst_idx) begin
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        #1;
        checkOutput("rst_mid_conv_out", int'(bus.conv_out), 0);
        checkOutput("rst_mid_conv_valid", int'(bus.conv_valid), 0);
        checkOutput("rst_mid_frame_done", int'(bus.frame_done), 0);
        checkOutput("rst_mid_frame_err", int'(bus.frame_err), 0);
        exp_q.delete();
        break;
      end
      if (p == 64 || p == abort_idx) begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        if (p == abort_idx) break;
      end else begin
        bus.pix_valid = 1'b1;
        bus.sof       = (p == 0);
        if (p == kwe_idx) begin
          bus.k_we   = 1'b1;
          bus.k_addr = 4'd0;
          bus.k_data = 8'd7;
        end
        r = p / 8;
        c = p % 8;
        if (r >= 2 && c >= 2)
          exp_q.push_back((exp_const >= 0) ? exp_const : 8 * (r - 1) + (c - 1));
      end
    end
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.k_we      = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int n_valid, input int n_done, input int n_left);
    idle(12);
    checkOutput({name, "_valid_count"}, valid_cnt - base_valid, n_valid);
    checkOutput({name, "_done_count"}, done_cnt - base_done, n_done);
    checkOutput({name, "_queue_left"}, exp_q.size(), n_left);
    exp_q.delete();
  endtask

  initial begin
    int k0, e0, d0;
    rst_n = 1'b1;
    bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.k_we = 1'b0;
    bus.k_addr = '0; bus.k_data = '0;
    bus.w11 = '0; bus.w12 = '0; bus.w13 = '0; bus.w21 = '0; bus.w22 = '0;
    bus.w23 = '0; bus.w31 = '0; bus.w32 = '0; bus.w33 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_conv_out", int'(bus.conv_out), 0);
    checkOutput("reset_conv_valid", int'(bus.conv_valid), 0);
    checkOutput("reset_frame_done", int'(bus.frame_done), 0);
    checkOutput("reset_frame_err", int'(bus.frame_err), 0);
    checkOutput("reset_k_err", int'(bus.k_err), 0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] all-ones kernel, constant 10");
    load_kernel(1, 1, 0);
    fill_const(10);
    applyStimulus(90, -1, -1, -1);
    finish_frame("ones", 36, 1, 0);

    $display("[TB] centre kernel, ramp, rejected writes");
    load_kernel(0, 1, 0);
    k0 = kerr_cnt;
    load_weight(12, 55);
    idle(2);
    checkOutput("idle_bad_addr_k_err", kerr_cnt - k0, 1);
    fill_ramp();
    k0 = kerr_cnt;
    applyStimulus(-1, -1, 20, -1);
    finish_frame("ramp", 36, 1, 0);
    checkOutput("run_write_k_err", kerr_cnt - k0, 1);
    checkOutput("first_output_latency", first_cyc - tap22_cyc, 4);

    $display("[TB] saturation, ReLU, negative bias");
    load_kernel(127, 127, 0);
    fill_const(255);
    applyStimulus(255, -1, -1, -1);
    finish_frame("sat", 36, 1, 0);
    load_kernel(-1, -1, 0);
    fill_const(5);
    applyStimulus(0, -1, -1, -1);
    finish_frame("relu", 36, 1, 0);
    load_kernel(0, 0, -128);
    fill_const(50);
    applyStimulus(0, -1, -1, -1);
    finish_frame("bias", 36, 1, 0);

    $display("[TB] abort at pixel (4,3) then full frame");
    load_kernel(0, 1, 0);
    fill_ramp();
    e0 = err_cnt;
    applyStimulus(-1, 35, -1, -1);
    finish_frame("abort", 11, 0, 2);
    checkOutput("abort_frame_err", err_cnt - e0, 1);
    e0 = err_cnt;
    applyStimulus(-1, -1, -1, -1);
    finish_frame("after_abort", 36, 1, 0);
    checkOutput("after_abort_frame_err", err_cnt - e0, 0);

    $display("[TB] reset at pixel (5,5)");
    e0 = err_cnt;
    d0 = done_cnt;
    applyStimulus(-1, -1, -1, 45);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    checkOutput("rst_no_frame_err", err_cnt - e0, 0);
    checkOutput("rst_no_frame_done", done_cnt - d0, 0);
    fill_const(10);
    applyStimulus(0, -1, -1, -1);
    finish_frame("post_reset", 36, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
